// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused per nibble,
// with the inter-nibble carry registered, so the critical path never spans WIDTH bits.

module carry_lookahead_adder_4 (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = in1 & in2;
        p    = in1 ^ in2;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [3:0]       cla_sum;
    logic             cla_cout;

    carry_lookahead_adder_4 u_cla (
        .in1  (op_a[3:0]),
        .in2  (op_b[3:0]),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // New nibble enters at the top; after NIB shifts nibble 0 has reached bits 3:0.
    always_comb begin
        acc_next = (acc >> 4) | (WIDTH'(cla_sum) << (WIDTH - 4));
        last     = (cnt == CNT_W'(NIB - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in1;
                        op_b  <= in2;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    acc   <= acc_next;
                    carry <= cla_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        sum  <= acc_next;
                        cout <= cla_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder at WIDTH=16, 4 and 32.

module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
    logic [15:0] in1_16, in2_16, sum16;
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
    logic [3:0]  in1_4, in2_4, sum4;
    logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, cout32;
    logic [31:0] in1_32, in2_32, sum32;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in1(in1_16), .in2(in2_16), .cin(cin16), .out_valid(out_valid16),
        .out_ready(out_ready16), .sum(sum16), .cout(cout16));

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1_4), .in2(in2_4), .cin(cin4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4));

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in1(in1_32), .in2(in2_32), .cin(cin32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .cout(cout32));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called 1ns after a rising edge with dut16 in IDLE; returns there in IDLE.
    task automatic do_add16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                            input int hold, output logic [15:0] s, output logic co,
                            output int lat, output logic rdy_seen);
        in1_16 = a; in2_16 = b; cin16 = ci; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; in1_16 = ~a; in2_16 = ~b; cin16 = ~ci;
        lat = 0;
        rdy_seen = in_ready16;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy_seen = rdy_seen | in_ready16;
        end
        s  = sum16;
        co = cout16;
        repeat (hold) begin
            @(posedge clk); #1;
            rdy_seen = rdy_seen | in_ready16;
        end
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic        co;
        logic        rdy;
        logic [16:0] ref17;
        logic [32:0] ref33;
        logic [32:0] q[$];
        logic [15:0] ra, rb;
        logic        rc;
        int          lat, sent, got, cyc;
        logic        hs_in;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[8] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
        vecs[9] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst_n = 1'b0;
        in_valid16 = 0; out_ready16 = 0; in1_16 = 0; in2_16 = 0; cin16 = 0;
        in_valid4 = 0; out_ready4 = 0; in1_4 = 0; in2_4 = 0; cin4 = 0;
        in_valid32 = 0; out_ready32 = 0; in1_32 = 0; in2_32 = 0; cin32 = 0;
        repeat (2) @(posedge clk); #1;
        chk("reset in_ready", in_ready16, 1'b1);
        chk("reset out_valid", out_valid16, 1'b0);
        chk("reset sum", sum16, 16'h0);
        chk("reset cout", cout16, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_add16(vecs[i].a, vecs[i].b, vecs[i].ci, i % 3, s, co, lat, rdy);
            chk($sformatf("vec%0d sum", i), s, vecs[i].s);
            chk($sformatf("vec%0d cout", i), co, vecs[i].co);
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d in_ready low while busy", i), rdy, 1'b0);
            chk($sformatf("vec%0d in_ready after out hs", i), in_ready16, 1'b1);
        end

        // Backpressure: result held while out_ready is low; in_valid pulses ignored.
        in1_16 = 16'h8000; in2_16 = 16'h8000; cin16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp out_valid c%0d", i), out_valid16, 1'b1);
            chk($sformatf("bp sum c%0d", i), sum16, 16'h0000);
            chk($sformatf("bp cout c%0d", i), cout16, 1'b1);
            chk($sformatf("bp in_ready c%0d", i), in_ready16, 1'b0);
            in_valid16 = (i % 2 == 0);
            in1_16 = 16'h1357; in2_16 = 16'h2468; cin16 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("bp idle in_ready", in_ready16, 1'b1);
        chk("bp idle out_valid", out_valid16, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("bp no phantom op", out_valid16, 1'b0);
        chk("bp sum held in idle", sum16, 16'h0000);
        chk("bp cout held in idle", cout16, 1'b1);

        // Reset in the middle of RUN.
        in1_16 = 16'h1234; in2_16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready16, 1'b1);
        chk("midrst out_valid", out_valid16, 1'b0);
        chk("midrst sum", sum16, 16'h0);
        chk("midrst cout", cout16, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_add16(16'h00FF, 16'h0F01, 1'b0, 0, s, co, lat, rdy);
        chk("post-rst sum", s, 16'h1000);
        chk("post-rst cout", co, 1'b0);
        chk("post-rst latency", lat, 4);

        // WIDTH=4: single-nibble RUN.
        in1_4 = 4'hF; in2_4 = 4'hF; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w4 latency", lat, 1);
        chk("w4 sum", sum4, 4'hF);
        chk("w4 cout", cout4, 1'b1);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("w4 in_ready", in_ready4, 1'b1);

        // Random WIDTH=16 through the directed handshake task.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ref17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            do_add16(ra, rb, rc, $urandom_range(0, 2), s, co, lat, rdy);
            chk("r16 sum", s, ref17[15:0]);
            chk("r16 cout", co, ref17[16]);
            chk("r16 latency", lat, 4);
        end

        // Random WIDTH=32 streaming with random backpressure and an in-order scoreboard.
        sent = 0; got = 0; cyc = 0; hs_in = 1'b0;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (hs_in) begin
                in_valid32 = 1'b0;
                hs_in = 1'b0;
            end
            if (!in_valid32 && sent < 1000 && $urandom_range(0, 1) == 1) begin
                in1_32 = $urandom; in2_32 = $urandom; cin32 = 1'($urandom);
                in_valid32 = 1'b1;
            end
            if (in_valid32 && in_ready32) begin
                q.push_back({1'b0, in1_32} + {1'b0, in2_32} + {32'h0, cin32});
                sent++;
                hs_in = 1'b1;
            end
            out_ready32 = 1'($urandom_range(0, 1));
            if (out_valid32 && out_ready32) begin
                if (q.size() == 0) begin
                    chk("r32 unexpected result", {cout32, sum32}, 33'h0);
                end else begin
                    ref33 = q.pop_front();
                    chk("r32 result", {cout32, sum32}, ref33);
                end
                got++;
            end
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b0;
        chk("r32 results received", got, 1000);
        chk("r32 inputs accepted", sent, 1000);
        chk("r32 scoreboard empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
